seq_div32: RTL and testbench



---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 25 ++
 rtl/seq_div32.sv | 168 ++++++++++++++++
 tb/tb_seq_div32.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 1;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step over the magnitude remainder/quotient pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o,
  output logic             ok_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One spare top bit so a failed subtract shows up as a negative difference.
  always_comb begin
    shifted = {r_i, q_i[WIDTH-1]};
    diff    = shifted - {2'b00, d_i};
    ok_o    = ~diff[WIDTH+1];
    r_o     = ok_o ? diff[WIDTH:0] : shifted[WIDTH:0];
    q_o     = {q_i[WIDTH-2:0], ok_o};
  end

endmodule

// File: rtl/seq_div32.sv
// Sequential signed divider: one quotient bit per clock on magnitudes, then a
// sign-fixup cycle, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for i_start
// CALC  | one restoring step per cycle, counter runs WIDTH..1
// SIGN  | apply result signs (or divide-by-zero values) to the outputs
// DONE  | o_done pulse, back to IDLE
import div_pkg::*;

module seq_div32 #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_CALC = 2'(CALC);
  localparam logic [1:0] ST_SIGN = 2'(SIGN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;
  logic             step_ok;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i  (r_q),
    .q_i  (q_q),
    .d_i  (d_q),
    .r_o  (step_r),
    .q_o  (step_q),
    .ok_o (step_ok)
  );

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    r_d        = r_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    dbz_pend_d = dbz_pend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          r_d = '0;
          if (i_divisor == '0) begin
            // Divide-by-zero parks the raw dividend in Q and lets SIGN publish
            // it, so results appear one edge after acceptance.
            q_d        = i_dividend;
            d_d        = '0;
            cnt_d      = '0;
            neg_q_d    = 1'b0;
            neg_r_d    = 1'b0;
            dbz_pend_d = 1'b1;
            state_d    = ST_SIGN;
          end else begin
            q_d        = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
            d_d        = i_divisor[WIDTH-1] ? -i_divisor : i_divisor;
            cnt_d      = CW'(WIDTH);
            neg_q_d    = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            neg_r_d    = i_dividend[WIDTH-1];
            dbz_pend_d = 1'b0;
            state_d    = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_SIGN;
        end
      end

      ST_SIGN: begin
        if (dbz_pend_q) begin
          quot_d = '1;
          rem_d  = q_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = neg_q_q ? -q_q : q_q;
          rem_d  = neg_r_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
          dbz_d  = 1'b0;
        end
        dbz_pend_d = 1'b0;
        state_d    = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dbz_pend_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      r_q        <= r_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      dbz_pend_q <= dbz_pend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
    end
  end

  // The step's new quotient LSB must be its own subtract-success decision.
  a_step_lsb : assert property (@(posedge i_clk) disable iff (reset)
    (state_q == ST_CALC) |-> (step_q[0] == step_ok));

  assign o_busy        = (state_q == ST_CALC) || (state_q == ST_SIGN);
  assign o_done        = (state_q == ST_DONE);
  assign o_quotient    = quot_q;
  assign o_remainder   = rem_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div32.sv
// Self-checking bench for seq_div32: directed corner cases, randomized operands
// against an arithmetic reference, start-while-busy, mid-op reset, throughput.
module tb_seq_div32;

  logic        i_clk;
  logic        reset;
  logic        i_start;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int NORM_LAT = 33;
  localparam int DBZ_LAT  = 1;

  seq_div32 dut (
    .i_clk         (i_clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: truncating signed division on 64-bit integers, cut to 32 bits.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic f, output int lat);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      f = 1'b1;
      lat = DBZ_LAT;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0];
      r = lr[31:0];
      f = 1'b0;
      lat = NORM_LAT;
    end
  endtask

  // Called just after an edge in IDLE; returns just after the edge following o_done.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic f, output int lat,
                         output logic busy_ok, output logic pulse_ok);
    q = '0; r = '0; f = 1'b0; lat = -1; pulse_ok = 1'b0;
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(posedge i_clk); #1;
    i_start    = 1'b0;
    i_dividend = $urandom;
    i_divisor  = $urandom;
    busy_ok = (o_busy === 1'b1);
    for (int k = 1; k <= 60; k++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1) begin
        lat = k;
        q = o_quotient;
        r = o_remainder;
        f = o_div_by_zero;
        busy_ok = busy_ok && (o_busy === 1'b0);
        break;
      end
      busy_ok = busy_ok && (o_busy === 1'b1);
    end
    @(posedge i_clk); #1;
    pulse_ok = (lat > 0) && (o_done === 1'b0) && (o_busy === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_start = 1'b0;
    i_dividend = '0;
    i_divisor = '0;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++;
    if ({o_busy, o_done, o_div_by_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got busy=%b done=%b dbz=%b exp 0 0 0", o_busy, o_done, o_div_by_zero);
    end
    n_checks++;
    if (o_quotient !== 32'd0 || o_remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_results got q=%h r=%h exp 0 0", o_quotient, o_remainder);
    end
    // start together with reset must lose
    i_start = 1'b1; i_dividend = 32'd100; i_divisor = 32'd7;
    @(posedge i_clk); #1;
    reset = 1'b0; i_start = 1'b0;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wins got busy=%b done=%b exp 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [7] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'd5, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb [7] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'd3, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] tq [7] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tr [7] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'd5, 32'd0, 32'd0, 32'd0};
    logic        tf [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int          tl [7] = '{33, 33, 33, 1, 33, 33, 33};
    logic [31:0] q, r;
    logic f, busy_ok, pulse_ok;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_div(ta[i], tb[i], q, r, f, lat, busy_ok, pulse_ok);
      n_checks++;
      if (lat != tl[i]) begin
        n_fail++;
        $display("FAIL dir_latency #%0d got %0d exp %0d", i, lat, tl[i]);
      end
      n_checks++;
      if (q !== tq[i] || r !== tr[i]) begin
        n_fail++;
        $display("FAIL dir_result #%0d %h/%h got q=%h r=%h exp q=%h r=%h", i, ta[i], tb[i], q, r, tq[i], tr[i]);
      end
      n_checks++;
      if (f !== tf[i]) begin
        n_fail++;
        $display("FAIL dir_dbz #%0d got %b exp %b", i, f, tf[i]);
      end
      n_checks++;
      if (!busy_ok || !pulse_ok) begin
        n_fail++;
        $display("FAIL dir_handshake #%0d got busy_ok=%b pulse_ok=%b exp 1 1", i, busy_ok, pulse_ok);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic f, ef, busy_ok, pulse_ok;
    int lat, elat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: b = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 20)) : 32'($urandom_range(1, 20));
        2: b = 32'd0;
        3: begin a = 32'h8000_0000; if ($urandom_range(0, 1) != 0) b = 32'hFFFF_FFFF; end
        4: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(51, 1000)); end
        default: a = -32'($urandom_range(0, 1000));
      endcase
      ref_div(a, b, eq, er, ef, elat);
      run_div(a, b, q, r, f, lat, busy_ok, pulse_ok);
      n_checks++;
      if (q !== eq || r !== er || f !== ef || lat != elat) begin
        n_fail++;
        $display("FAIL rand #%0d %h/%h got q=%h r=%h f=%b lat=%0d exp q=%h r=%h f=%b lat=%0d",
                 i, a, b, q, r, f, lat, eq, er, ef, elat);
      end
      n_checks++;
      if (!busy_ok || !pulse_ok) begin
        n_fail++;
        $display("FAIL rand_handshake #%0d got busy_ok=%b pulse_ok=%b exp 1 1", i, busy_ok, pulse_ok);
      end
    end
  endtask

  task automatic test_ignored_start();
    int ndone = 0;
    int lat = -1;
    logic [31:0] q = '0, r = '0;
    i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1) begin
        ndone++;
        lat = k; q = o_quotient; r = o_remainder;
      end
      if (k == 9) begin
        i_start = 1'b1; i_dividend = 32'd50; i_divisor = 32'd5;
      end else begin
        i_start = 1'b0;
      end
    end
    n_checks++;
    if (ndone != 1 || lat != NORM_LAT) begin
      n_fail++;
      $display("FAIL ignored_start_pulses got n=%0d lat=%0d exp n=1 lat=%0d", ndone, lat, NORM_LAT);
    end
    n_checks++;
    if (q !== 32'd14 || r !== 32'd2) begin
      n_fail++;
      $display("FAIL ignored_start_result got q=%0d r=%0d exp 14 2", q, r);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] q, r;
    logic f, busy_ok, pulse_ok;
    int lat;
    int ndone = 0;
    run_div(32'd7, 32'd0, q, r, f, lat, busy_ok, pulse_ok);
    n_checks++;
    if (f !== 1'b1 || o_div_by_zero !== 1'b1 || r !== 32'd7) begin
      n_fail++;
      $display("FAIL dbz_hold got f=%b held=%b r=%h exp 1 1 7", f, o_div_by_zero, r);
    end
    i_dividend = 32'd1000; i_divisor = 32'd3; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1) ndone++;
    end
    reset = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if ({o_busy, o_done, o_div_by_zero} !== 3'b000 || o_quotient !== 32'd0 || o_remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_clear got busy=%b done=%b dbz=%b q=%h r=%h exp all 0",
               o_busy, o_done, o_div_by_zero, o_quotient, o_remainder);
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done got %0d pulses exp 0", ndone);
    end
    run_div(32'd1000, 32'd3, q, r, f, lat, busy_ok, pulse_ok);
    n_checks++;
    if (q !== 32'd333 || r !== 32'd1 || f !== 1'b0 || lat != NORM_LAT) begin
      n_fail++;
      $display("FAIL after_reset_div got q=%0d r=%0d f=%b lat=%0d exp 333 1 0 %0d", q, r, f, lat, NORM_LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    logic f, busy_ok, pulse_ok;
    int lat;
    time t [3];
    logic [31:0] a [3] = '{32'd77, 32'hFFFF_FC18, 32'd123456};
    logic [31:0] b [3] = '{32'd5, 32'd9, 32'hFFFF_FFF5};
    logic [31:0] eq, er;
    logic ef;
    int elat;
    for (int i = 0; i < 3; i++) begin
      t[i] = $time;
      ref_div(a[i], b[i], eq, er, ef, elat);
      run_div(a[i], b[i], q, r, f, lat, busy_ok, pulse_ok);
      n_checks++;
      if (q !== eq || r !== er || f !== ef || lat != elat) begin
        n_fail++;
        $display("FAIL b2b_result #%0d got q=%h r=%h f=%b lat=%0d exp q=%h r=%h f=%b lat=%0d",
                 i, q, r, f, lat, eq, er, ef, elat);
      end
    end
    n_checks++;
    if ((t[1] - t[0]) != 350 || (t[2] - t[1]) != 350) begin
      n_fail++;
      $display("FAIL b2b_throughput got %0t %0t exp 350 350", t[1] - t[0], t[2] - t[1]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
